// File: rtl/instr_fetcher_pkg.sv
// Shared fetch-stage definitions: decoder group codes, fetch FSM states, buffer sizing.
// No logic; imported by the fetcher and its byte buffer.
package instr_fetcher_pkg;

   localparam int FETCH_MAX_BYTES    = 4;
   localparam int FETCH_OP_BYTES_MAX = 2;

   // Group codes returned by the decoder next to this block.
   localparam logic [7:0] INSN_GROUP_NOP             = 8'h00;
   localparam logic [7:0] INSN_GROUP_LD_DD_NN        = 8'h01;
   localparam logic [7:0] INSN_GROUP_LD_DD_IND_NN    = 8'h02;
   localparam logic [7:0] INSN_GROUP_BLOCK_TRANSFER  = 8'h03;
   localparam logic [7:0] INSN_GROUP_ILLEGAL_INSTR   = 8'hFE;
   localparam logic [7:0] INSN_GROUP_NEED_MORE_BYTES = 8'hFF;

   typedef enum logic [1:0] {
      FETCH_STATE_IDLE = 2'd0,
      FETCH_STATE_REQ  = 2'd1,
      FETCH_STATE_EVAL = 2'd2,
      FETCH_STATE_DONE = 2'd3
   } fetch_state_t;

   typedef enum logic {
      PHASE_OPCODE  = 1'b0,
      PHASE_OPERAND = 1'b1
   } fetch_phase_t;

   function automatic logic [15:0] pc_add(input logic [15:0] base, input logic [2:0] off);
      return base + {13'd0, off};
   endfunction

endpackage

// File: rtl/instr_byte_buf.sv
// Four-byte instruction buffer: synchronous clear, little-endian write at the current count.
// Write takes effect next cycle; writes past the last byte are dropped.
module instr_byte_buf
   import instr_fetcher_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clr,
   input  logic        i_wr,
   input  logic [7:0]  i_wr_dat,
   output logic [31:0] o_buf,
   output logic [2:0]  o_cnt
);

   localparam logic [2:0] CNT_MAX = 3'(FETCH_MAX_BYTES);

   logic [31:0] r_buf;
   logic [2:0]  r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (i_wr && (r_cnt < CNT_MAX)) begin
         r_buf[{r_cnt[1:0], 3'b000} +: 8] <= i_wr_dat;
         r_cnt <= r_cnt + 3'd1;
      end
   end

   assign o_buf = r_buf;
   assign o_cnt = r_cnt;

endmodule

// File: rtl/instr_fetcher.sv
// Byte-serial instruction fetch: 2 cycles per byte with zero-wait memory, out_valid held until out_ready.
// Optional FETCH_M1_EN adds m1 (opcode-fetch cycle) and r_inc (refresh increment pulse) outputs.
module instr_fetcher
   import instr_fetcher_pkg::*;
#(
   parameter int MAX_BYTES    = FETCH_MAX_BYTES,
   parameter int OP_BYTES_MAX = FETCH_OP_BYTES_MAX
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] pc_in,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        mem_ack,
   output logic [31:0] dec_instr,
   output logic [1:0]  dec_op_len,
   input  logic [2:0]  dec_len,
   input  logic [7:0]  dec_group,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [2:0]  out_len,
   output logic [7:0]  out_group,
   output logic [15:0] out_pc_next,
   output logic        busy
`ifdef FETCH_M1_EN
   ,
   output logic        m1,
   output logic        r_inc
`endif
);

   localparam logic [2:0] LEN_MAX = 3'(MAX_BYTES);
   localparam logic [1:0] OP_MAX  = 2'(OP_BYTES_MAX);

   fetch_state_t r_state;
   fetch_phase_t r_phase;
   logic [15:0]  r_pc_base, r_mem_addr, r_pc_next;
   logic         r_mem_rd, r_out_vld;
   logic [1:0]   r_op_len;
   logic [2:0]   r_len, r_out_len;
   logic [7:0]   r_grp, r_out_grp;

   logic [31:0]  w_buf;
   logic [2:0]   w_cnt, w_dec_len, w_len_sel;
   logic [7:0]   w_grp_sel;
   logic         w_need_more, w_clr, w_wr;

   assign w_clr = (r_state == FETCH_STATE_IDLE) && start;
   assign w_wr  = (r_state == FETCH_STATE_REQ) && mem_ack;

   instr_byte_buf u_buf (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clr    (w_clr),
      .i_wr     (w_wr),
      .i_wr_dat (mem_data),
      .o_buf    (w_buf),
      .o_cnt    (w_cnt)
   );

   // Decoder answers are only trusted while still in the opcode phase; afterwards the latched copy rules.
   always_comb begin
      w_dec_len   = (dec_len > LEN_MAX) ? LEN_MAX : dec_len;
      w_len_sel   = (r_phase == PHASE_OPCODE) ? w_dec_len : r_len;
      w_grp_sel   = (r_phase == PHASE_OPCODE) ? dec_group : r_grp;
      w_need_more = (r_phase == PHASE_OPCODE) && (dec_group == INSN_GROUP_NEED_MORE_BYTES);
   end

`ifdef FETCH_M1_EN
   logic r_m1, r_inc_pls;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= FETCH_STATE_IDLE;
         r_phase    <= PHASE_OPCODE;
         r_pc_base  <= '0;
         r_mem_addr <= '0;
         r_mem_rd   <= 1'b0;
         r_op_len   <= '0;
         r_len      <= '0;
         r_grp      <= '0;
         r_out_vld  <= 1'b0;
         r_out_len  <= '0;
         r_out_grp  <= '0;
         r_pc_next  <= '0;
`ifdef FETCH_M1_EN
         r_m1       <= 1'b0;
         r_inc_pls  <= 1'b0;
`endif
      end else begin
`ifdef FETCH_M1_EN
         r_inc_pls <= 1'b0;
`endif
         case (r_state)
            FETCH_STATE_IDLE: begin
               if (start) begin
                  r_pc_base  <= pc_in;
                  r_mem_addr <= pc_in;
                  r_mem_rd   <= 1'b1;
                  r_op_len   <= '0;
                  r_phase    <= PHASE_OPCODE;
                  r_state    <= FETCH_STATE_REQ;
`ifdef FETCH_M1_EN
                  r_m1       <= 1'b1;
`endif
               end
            end
            FETCH_STATE_REQ: begin
               if (mem_ack) begin
                  r_mem_rd <= 1'b0;
                  if (r_phase == PHASE_OPCODE)
                     r_op_len <= r_op_len + 2'd1;
                  r_state  <= FETCH_STATE_EVAL;
`ifdef FETCH_M1_EN
                  r_m1      <= 1'b0;
                  r_inc_pls <= (r_phase == PHASE_OPCODE);
`endif
               end
            end
            FETCH_STATE_EVAL: begin
               if (w_need_more && (r_op_len < OP_MAX)) begin
                  r_mem_addr <= pc_add(r_pc_base, w_cnt);
                  r_mem_rd   <= 1'b1;
                  r_state    <= FETCH_STATE_REQ;
`ifdef FETCH_M1_EN
                  r_m1       <= 1'b1;
`endif
               end else if (w_need_more) begin
                  // Decoder still unresolved after the last opcode byte: give up as illegal.
                  r_out_grp <= INSN_GROUP_ILLEGAL_INSTR;
                  r_out_len <= 3'(OP_BYTES_MAX);
                  r_pc_next <= pc_add(r_pc_base, 3'(OP_BYTES_MAX));
                  r_out_vld <= 1'b1;
                  r_state   <= FETCH_STATE_DONE;
               end else begin
                  if (r_phase == PHASE_OPCODE) begin
                     r_len   <= w_dec_len;
                     r_grp   <= dec_group;
                     r_phase <= PHASE_OPERAND;
                  end
                  if (w_cnt < w_len_sel) begin
                     r_mem_addr <= pc_add(r_pc_base, w_cnt);
                     r_mem_rd   <= 1'b1;
                     r_state    <= FETCH_STATE_REQ;
                  end else begin
                     r_out_grp <= w_grp_sel;
                     r_out_len <= w_len_sel;
                     r_pc_next <= pc_add(r_pc_base, w_len_sel);
                     r_out_vld <= 1'b1;
                     r_state   <= FETCH_STATE_DONE;
                  end
               end
            end
            FETCH_STATE_DONE: begin
               if (out_ready) begin
                  r_out_vld <= 1'b0;
                  r_state   <= FETCH_STATE_IDLE;
               end
            end
            default: r_state <= FETCH_STATE_IDLE;
         endcase
      end
   end

   assign mem_rd      = r_mem_rd;
   assign mem_addr    = r_mem_addr;
   assign dec_instr   = w_buf;
   assign dec_op_len  = r_op_len;
   assign out_valid   = r_out_vld;
   assign out_instr   = w_buf;
   assign out_len     = r_out_len;
   assign out_group   = r_out_grp;
   assign out_pc_next = r_pc_next;
   assign busy        = (r_state != FETCH_STATE_IDLE);
`ifdef FETCH_M1_EN
   assign m1          = r_m1;
   assign r_inc       = r_inc_pls;
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: byte memory responder with wait states, small decoder model.
// Define FETCH_M1_EN for both bench and RTL to cover the m1/r_inc outputs.
module tb_instr_fetcher;
   import instr_fetcher_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] pc_in = '0;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] dec_instr;
   logic [1:0]  dec_op_len;
   logic [2:0]  dec_len;
   logic [7:0]  dec_group;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [2:0]  out_len;
   logic [7:0]  out_group;
   logic [15:0] out_pc_next;
   logic        busy;
`ifdef FETCH_M1_EN
   logic        m1, r_inc;
`endif

   instr_fetcher dut (
      .clk(clk), .reset_n(reset_n), .start(start), .pc_in(pc_in),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
      .dec_instr(dec_instr), .dec_op_len(dec_op_len), .dec_len(dec_len), .dec_group(dec_group),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_len(out_len),
      .out_group(out_group), .out_pc_next(out_pc_next), .busy(busy)
`ifdef FETCH_M1_EN
      , .m1(m1), .r_inc(r_inc)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Decoder model: ED/DD are prefixes needing a second opcode byte.
   always_comb begin
      dec_group = INSN_GROUP_NEED_MORE_BYTES;
      dec_len   = 3'd0;
      if (dec_op_len != 2'd0) begin
         case (dec_instr[7:0])
            8'h00: begin dec_group = INSN_GROUP_NOP;      dec_len = 3'd1; end
            8'h01: begin dec_group = INSN_GROUP_LD_DD_NN; dec_len = 3'd3; end
            8'hED, 8'hDD: begin
               if (dec_op_len == 2'd2) begin
                  if (dec_instr[15:8] == 8'h4B) begin
                     dec_group = INSN_GROUP_LD_DD_IND_NN; dec_len = 3'd4;
                  end else if (dec_instr[15:8] == 8'hB0) begin
                     dec_group = INSN_GROUP_BLOCK_TRANSFER; dec_len = 3'd2;
                  end
               end
            end
            default: begin dec_group = INSN_GROUP_ILLEGAL_INSTR; dec_len = 3'd1; end
         endcase
      end
   end

   // Memory responder: n_wait idle cycles per request, then a one-cycle ack.
   logic [7:0]  mem [0:65535];
   int          n_wait = 0;
   int          wait_left = 0;
   logic        rsp_en = 1'b1;
   logic        late_ack = 1'b0;
   logic        in_req = 1'b0;
   logic [15:0] rq_addr = '0;
   logic [15:0] cur_pc = '0;
   logic [15:0] nbyte = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rsp_en) begin
            mem_ack  = late_ack;
            mem_data = 8'hAA;
            in_req   = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            in_req  = 1'b0;
         end else if (mem_rd || in_req) begin
            if (in_req) begin
               chk("rd_hold", {15'd0, mem_rd, mem_addr}, {16'd1, rq_addr});
            end else begin
               in_req    = 1'b1;
               rq_addr   = mem_addr;
               wait_left = 0;
               chk("req_addr", {16'd0, mem_addr}, {16'd0, 16'(cur_pc + nbyte)});
            end
            if (wait_left >= n_wait) begin
               mem_ack  = 1'b1;
               mem_data = mem[mem_addr];
               nbyte    = nbyte + 16'd1;
            end else begin
               wait_left++;
            end
         end
      end
   end

`ifdef FETCH_M1_EN
   int m1_cyc = 0;
   int inc_cnt = 0;
   always @(negedge clk) begin
      if (m1) m1_cyc++;
      if (r_inc) inc_cnt++;
   end
`endif

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic [31:0] bytes;
      int          nwait;
      logic [31:0] e_instr;
      logic [2:0]  e_len;
      logic [7:0]  e_grp;
      logic [15:0] e_pcn;
      int          e_cyc;
      logic [1:0]  e_oplen;
   } vec_t;

   vec_t vecs[6];

   task automatic load_mem(input logic [15:0] pc, input logic [31:0] bytes);
      for (int k = 0; k < 4; k++) mem[16'(pc + 16'(k))] = bytes[8*k +: 8];
   endtask

   task automatic fetch_until_valid(input logic [15:0] pc, input int nw, output int cyc);
      n_wait = nw;
      cur_pc = pc;
      nbyte  = '0;
      @(negedge clk);
      start = 1'b1;
      pc_in = pc;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      load_mem(v.pc, v.bytes);
      fetch_until_valid(v.pc, v.nwait, cyc);
      chk({v.name, "/cycles"}, 32'(cyc), 32'(v.e_cyc));
      chk({v.name, "/instr"}, out_instr, v.e_instr);
      chk({v.name, "/len"}, 32'(out_len), 32'(v.e_len));
      chk({v.name, "/group"}, 32'(out_group), 32'(v.e_grp));
      chk({v.name, "/pc_next"}, 32'(out_pc_next), 32'(v.e_pcn));
      chk({v.name, "/op_len"}, 32'(dec_op_len), 32'(v.e_oplen));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({v.name, "/valid_drop"}, 32'(out_valid), 32'd0);
      chk({v.name, "/idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int a = 0; a < 65536; a++) mem[a] = 8'hAA;

      vecs[0] = '{"nop",     16'h1000, 32'hAAAAAA00, 0, 32'h00000000, 3'd1, INSN_GROUP_NOP,           16'h1001, 3,  2'd1};
      vecs[1] = '{"ld_bc",   16'h2000, 32'hAA123401, 0, 32'h00123401, 3'd3, INSN_GROUP_LD_DD_NN,      16'h2003, 7,  2'd1};
      vecs[2] = '{"ed4b",    16'hFFFE, 32'h56784BED, 0, 32'h56784BED, 3'd4, INSN_GROUP_LD_DD_IND_NN,  16'h0002, 9,  2'd2};
      vecs[3] = '{"dd_wait", 16'h3000, 32'hAAAA00DD, 3, 32'h000000DD, 3'd2, INSN_GROUP_ILLEGAL_INSTR, 16'h3002, 11, 2'd2};
      vecs[4] = '{"ill_pass",16'h4000, 32'hAAAAAAFF, 1, 32'h000000FF, 3'd1, INSN_GROUP_ILLEGAL_INSTR, 16'h4001, 4,  2'd1};
      vecs[5] = '{"edb0",    16'h5000, 32'hAAAAB0ED, 0, 32'h0000B0ED, 3'd2, INSN_GROUP_BLOCK_TRANSFER,16'h5002, 5,  2'd2};

      // Reset state
      #12;
      chk("rst/mem_rd", 32'(mem_rd), 32'd0);
      chk("rst/mem_addr", 32'(mem_addr), 32'd0);
      chk("rst/dec_instr", dec_instr, 32'd0);
      chk("rst/dec_op_len", 32'(dec_op_len), 32'd0);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/out_len", 32'(out_len), 32'd0);
      chk("rst/out_group", 32'(out_group), 32'd0);
      chk("rst/out_pc_next", 32'(out_pc_next), 32'd0);
      chk("rst/busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Backpressure: outputs frozen and start ignored while out_ready is low
      fetch_until_valid(16'h2000, 0, cyc);
      chk("bp/cycles", 32'(cyc), 32'd7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'b1;
         pc_in = 16'h7777;
         @(posedge clk);
         #1;
         chk("bp/valid", 32'(out_valid), 32'd1);
         chk("bp/instr", out_instr, 32'h00123401);
         chk("bp/len", 32'(out_len), 32'd3);
         chk("bp/pc_next", 32'(out_pc_next), 32'h2003);
         chk("bp/mem_rd", 32'(mem_rd), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      out_ready = 1'b0;
      chk("bp/hs_valid", 32'(out_valid), 32'd0);
      chk("bp/hs_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("bp/no_restart_rd", 32'(mem_rd), 32'd0);
      chk("bp/no_restart_busy", 32'(busy), 32'd0);

      // Reset in the middle of a long memory wait
      load_mem(16'h6000, 32'hAAAAAA00);
      n_wait = 20;
      cur_pc = 16'h6000;
      nbyte  = '0;
      @(negedge clk);
      start = 1'b1;
      pc_in = 16'h6000;
      @(posedge clk);
      #1;
      start  = 1'b0;
      rsp_en = 1'b0;
      chk("mid/mem_rd", 32'(mem_rd), 32'd1);
      chk("mid/mem_addr", 32'(mem_addr), 32'h6000);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid/rst_rd", 32'(mem_rd), 32'd0);
      chk("mid/rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      late_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      late_ack = 1'b0;
      chk("late/busy", 32'(busy), 32'd0);
      chk("late/instr", dec_instr, 32'd0);
      chk("late/op_len", 32'(dec_op_len), 32'd0);
      chk("late/valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rsp_en = 1'b1;
      run_vec(vecs[0]);

`ifdef FETCH_M1_EN
      begin
         int m1_base, inc_base;
         m1_base  = m1_cyc;
         inc_base = inc_cnt;
         run_vec(vecs[5]);
         chk("m1/edb0_cycles", 32'(m1_cyc - m1_base), 32'd2);
         chk("m1/edb0_inc", 32'(inc_cnt - inc_base), 32'd2);
         m1_base  = m1_cyc;
         inc_base = inc_cnt;
         run_vec(vecs[1]);
         chk("m1/ld_cycles", 32'(m1_cyc - m1_base), 32'd1);
         chk("m1/ld_inc", 32'(inc_cnt - inc_base), 32'd1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
Fetch stage directly upstream of the instruction decoder. Reads opcode and operand bytes one at a time over a byte-wide memory handshake and assembles them little-endian into a 32-bit buffer. Presents the buffer and the opcode-byte count to the decoder, and uses the decoder's len/group answer to decide whether to fetch more bytes. Delivers the complete instruction to the execute stage over a valid/ready handshake.

Parameters:
MAX_BYTES, 4, instruction buffer depth in bytes; fixed by the 32-bit decoder interface.
OP_BYTES_MAX, 2, maximum opcode (non-operand) bytes the decoder resolves.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
start  in  1  pulse: begin fetching at pc_in; honoured only in IDLE.
pc_in  in  16  address of the first instruction byte.
mem_rd  out  1  read request; held until mem_ack.
mem_addr  out  16  byte address; stable while mem_rd=1.
mem_data  in  8  read data; valid in the mem_ack cycle.
mem_ack  in  1  read complete.
dec_instr  out  32  assembled bytes to the decoder; byte k at [8k+7:8k]; unfetched bytes are 0.
dec_op_len  out  2  opcode bytes fetched so far.
dec_len  in  3  decoder total length.
dec_group  in  8  decoder group (INSN_GROUP_*).
out_valid  out  1  instruction complete.
out_ready  in  1  execute stage accepts.
out_instr  out  32  completed instruction bytes.
out_len  out  3  total length.
out_group  out  8  latched group.
out_pc_next  out  16  (start PC + out_len) mod 2^16.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. mem_rd=0, mem_addr=0, buffer=0, dec_op_len=0, byte count=0, out_valid=0, out_len=0, out_group=0, out_pc_next=0. Reset mid-fetch abandons the fetch; a late mem_ack is ignored.
- States: IDLE, REQ, EVAL, DONE.
- IDLE: if start=1, latch pc_in into pc_base, clear the buffer, set cnt=0 and dec_op_len=0, set phase=OPCODE, and go to REQ.
- REQ:
  - mem_rd=1, mem_addr=pc_base+cnt (16-bit wrap, so FFFF+1 gives 0000).
  - On mem_ack: write mem_data into byte cnt, increment cnt, and if phase=OPCODE also increment dec_op_len. Go to EVAL.
  - mem_rd drops in EVAL.
- EVAL: one cycle. The decoder sees the updated buffer and op_len.
  - If phase=OPCODE and dec_group=NEED_MORE_BYTES and dec_op_len<2: go to REQ (another opcode byte).
  - If phase=OPCODE and dec_group=NEED_MORE_BYTES and dec_op_len=2: force out_group=ILLEGAL_INSTR, out_len=2, go to DONE.
  - Otherwise, if phase=OPCODE: latch dec_len and dec_group into len_q/grp_q and set phase=OPERAND. Operand bytes never change dec_op_len.
  - Then if cnt<len_q: go to REQ. If cnt==len_q: go to DONE.
- DONE:
  - out_valid=1. out_instr/out_len/out_group/out_pc_next are stable until the handshake completes.
  - On out_valid & out_ready: go to IDLE and drop out_valid next cycle.
  - start in DONE, including the handshake cycle, is ignored.
- ILLEGAL_INSTR from the decoder is passed through with the decoder's len and no further fetching.
- Latency with zero-wait memory (ack in the first REQ cycle):
  - 2 cycles per byte.
  - start sampled at cycle 0 gives REQ at 1 and out_valid at 1+2·len.
  - Each wait state adds 1 cycle.
- Invariants: cnt≤4; dec_op_len≤cnt; mem_rd never high outside REQ.

Optional Feature:
FETCH_M1_EN.
- Defined: adds outputs m1 (1 bit) and r_inc (1 bit).
  - m1=1 during REQ while phase=OPCODE.
  - r_inc pulses for one cycle on each opcode-byte mem_ack, to drive the refresh register.
- Undefined: neither port exists and no logic is added.

Decomposition:
- Shared header z80.vh holds:
  - existing INSN_GROUP_* macros;
  - new fetch state encodings FETCH_STATE_IDLE/REQ/EVAL/DONE;
  - FETCH_MAX_BYTES=4.
- The decoder is instantiated beside this block at the next level up, not inside it.
- One natural sub-module: instr_byte_buf. It is the 4-byte clear/write-at-index buffer with count.

Test Plan:
- NOP: start, pc_in=0x1000, mem 00, zero-wait -> out_valid at cycle 3, instr=0x00000000, len=1, group=NOP, pc_next=0x1001.
- LD BC,nn: bytes 01 34 12 -> dec_op_len stays 1 after byte 0; out_instr=0x00123401, len=3, pc_next=base+3.
- Prefix: ED 4B 78 56 -> op_len reaches 2; out_instr=0x56784BED, len=4, group=LD_DD_IND_NN; addr wraps from pc_in=0xFFFE to 0x0001.
- Wait states plus illegal: 3 wait cycles per byte, bytes DD 00 -> group=ILLEGAL_INSTR, len=2, mem_rd held with stable addr during waits.
- Backpressure/reset: out_ready=0 for 5 cycles -> outputs stable and start ignored; reset_n=0 mid-REQ -> mem_rd=0 immediately, state IDLE, late ack ignored.
- With FETCH_M1_EN, ED B0: m1 high for both fetches, two r_inc pulses.
